inst_fetch: RTL and testbench

Instruction fetch stage directly upstream of the main opcode decoder. It holds the PC, issues one-at-a-time requests to instruction memory over a request/response handshake, and latches the returned word. It presents the word with a valid flag to decode; the decoder consumes `inst[31:26]`. It computes the next PC from sequential, branch, jump and flush sources.

---
 rtl/mips_defs.sv | 20 ++
 rtl/pc_next.sv | 29 ++
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, reset vector
// and instruction field bounds.
package mips_defs;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_HI   = 31;
  localparam int unsigned OP_LO   = 26;
  localparam int unsigned JIDX_HI = 25;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: flush > jump > taken branch > sequential.
module pc_next
  import mips_defs::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic             jump,
  input  logic [JIDX_HI:0] jump_index,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             flush,
  input  logic [XLEN-1:0]  flush_target,
  output logic [XLEN-1:0]  pc_plus4_c,
  output logic [XLEN-1:0]  next_pc_c
);

  assign pc_plus4_c = pc + XLEN'(4);

  always_comb begin
    next_pc_c = pc_plus4_c;
    if (flush) begin
      next_pc_c = {flush_target[XLEN-1:2], 2'b00};
    end else if (jump) begin
      next_pc_c = {pc_plus4_c[XLEN-1:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc_c = {branch_target[XLEN-1:2], 2'b00};
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding imem request/response, latches the
// returned word for decode and steers the PC on consume or flush.
module inst_fetch
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  inst,
  output logic             inst_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  input  logic             stall,
  input  logic             jump,
  input  logic [JIDX_HI:0] jump_index,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             flush,
  input  logic [XLEN-1:0]  flush_target
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic            load_pc;
  logic            latch_inst;
  logic [XLEN-1:0] next_pc;

  pc_next u_pc_next (
    .pc            (pc),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_target  (flush_target),
    .pc_plus4_c    (pc_plus4),
    .next_pc_c     (next_pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flush overrides everything; a response seen under flush is always dropped.
  always_comb begin
    state_d    = state_q;
    load_pc    = flush;
    latch_inst = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rvalid) begin
          state_d    = ST_VALID;
          latch_inst = 1'b1;
        end
      end
      ST_VALID: begin
        if (flush || !stall) begin
          state_d = ST_FETCH;
          load_pc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!flush && imem_rvalid) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      if (load_pc) begin
        pc <= next_pc;
      end
      if (latch_inst) begin
        inst <= imem_rdata;
      end
      inst_valid <= (state_d == ST_VALID);
      imem_req   <= (state_d == ST_FETCH);
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a latency-programmable instruction memory.
module tb_inst_fetch;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_target;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cnt      = 0;
  logic [31:0] req_addr = '0;
  logic [5:0]  opcode;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .stall         (stall),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_target  (flush_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : (a ^ 32'h8C00_0000);
  endfunction

  // Memory model: answers a request 'lat' cycles after the request cycle.
  always @(negedge clk) begin
    if (rst) begin
      cnt         = 0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (cnt != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(req_addr);
        end
      end
      if (imem_req) begin
        cnt      = lat;
        req_addr = imem_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    if (inst_valid !== 1'b1) check({tag, "_timeout"}, 32'(inst_valid), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},       pc,                 32'h0);
    check({tag, "_inst"},     inst,               32'h0);
    check({tag, "_valid"},    32'(inst_valid),    32'h0);
    check({tag, "_req"},      32'(imem_req),      32'h0);
    check({tag, "_addr"},     imem_addr,          32'h0);
    check({tag, "_pcplus4"},  pc_plus4,           32'h4);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_index = '0;
    branch_taken = 1'b0; branch_target = '0; flush = 1'b0; flush_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    step(); step();
    check_reset_outputs("rst");

    // Reset release and first fetch with a 1-cycle memory
    rst = 1'b0;
    check("idle_req", 32'(imem_req), 32'h0);
    step();
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h0);
    step();
    check("wait_req", 32'(imem_req), 32'h0);
    step();
    check("first_valid", 32'(inst_valid), 32'h1);
    check("first_inst", inst, 32'h2008_0005);
    check("first_pc", pc, 32'h0);
    opcode = inst[OP_HI:OP_LO];
    check("first_opcode", 32'(opcode), 32'h8);

    // Stall holds the instruction for 5 cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(inst_valid), 32'h1);
      check("stall_inst", inst, 32'h2008_0005);
      check("stall_pc", pc, 32'h0);
      check("stall_req", 32'(imem_req), 32'h0);
    end
    stall = 1'b0;
    step();
    check("seq_req", 32'(imem_req), 32'h1);
    check("seq_addr", imem_addr, 32'h4);

    // Flush from FETCH goes through DRAIN to 1000_0010
    flush = 1'b1; flush_target = 32'h1000_0010;
    step();
    flush = 1'b0;
    check("drain_valid", 32'(inst_valid), 32'h0);
    check("drain_req", 32'(imem_req), 32'h0);
    step();
    check("redir_req", 32'(imem_req), 32'h1);
    check("redir_addr", imem_addr, 32'h1000_0010);
    wait_valid("jmp");
    check("jmp_pc", pc, 32'h1000_0010);

    // Jump beats a simultaneous taken branch
    jump = 1'b1; jump_index = 26'h000_0040;
    branch_taken = 1'b1; branch_target = 32'h0000_0800;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    check("jump_addr", imem_addr, 32'h1000_0100);
    wait_valid("br");
    check("br_pc", pc, 32'h1000_0100);

    // Taken branch with unaligned target; next fetch uses a 4-cycle memory
    branch_taken = 1'b1; branch_target = 32'h0000_0203; lat = 4;
    step();
    branch_taken = 1'b0;
    check("branch_addr", imem_addr, 32'h0000_0200);
    step();
    flush = 1'b1; flush_target = 32'h0000_0380;
    step();
    flush = 1'b0;
    begin
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
        check("stale_valid", 32'(inst_valid), 32'h0);
        step();
        n++;
      end
    end
    check("flush_wait_addr", imem_addr, 32'h0000_0380);
    wait_valid("fw");
    check("flush_wait_inst", inst, 32'h8C00_0380);
    lat = 1;

    // Flush coincident with the response in WAIT skips DRAIN
    step();
    check("coinc_fetch_addr", imem_addr, 32'h0000_0384);
    step();
    check("coinc_rvalid", 32'(imem_rvalid), 32'h1);
    flush = 1'b1; flush_target = 32'h0000_03C0;
    step();
    flush = 1'b0;
    check("coinc_req", 32'(imem_req), 32'h1);
    check("coinc_addr", imem_addr, 32'h0000_03C0);
    check("coinc_valid", 32'(inst_valid), 32'h0);
    check("coinc_inst", inst, 32'h8C00_0380);

    // PC wrap at the top of the address space
    wait_valid("wrap");
    flush = 1'b1; flush_target = 32'hFFFF_FFFF;
    step();
    flush = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pcplus4", pc_plus4, 32'h0);

    // Reset asserted while in DRAIN
    flush = 1'b1; flush_target = 32'h0000_0040;
    step();
    flush = 1'b0;
    check("pre_rst_pc", pc, 32'h0000_0040);
    rst = 1'b1;
    #1;
    check_reset_outputs("drain_rst");
    step();
    rst = 1'b0;
    step();
    check("rerun_req", 32'(imem_req), 32'h1);
    check("rerun_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
